// File: rtl/pc_ras_pkg.sv
// pc_ras_pkg: shared defaults and next-PC select encodings for the pc_ras fetch block.
package pc_ras_pkg;
    localparam int DEF_DATAWIDTH = 16;
    localparam int DEF_IMMWIDTH  = 8;

    typedef enum logic [2:0] {
        NPC_SEQ,
        NPC_BR,
        NPC_JMP,
        NPC_CALL,
        NPC_RET,
        NPC_SWAP
    } npc_sel_e;

    // A ret against an empty stack falls back to sequential, unless call is also set
    function automatic npc_sel_e npc_select(input logic branch, input logic jump, input logic call,
                                            input logic ret, input logic empty);
        return (ret && !empty) ? (call ? NPC_SWAP : NPC_RET) :
               call            ? NPC_CALL :
               ret             ? NPC_SEQ  :
               jump            ? NPC_JMP  :
               branch          ? NPC_BR   : NPC_SEQ;
    endfunction
endpackage

// File: rtl/pc_ras_if.sv
// pc_ras_if: decode-side strobes and fetch-side PC/stack status of the pc_ras block.
interface pc_ras_if
    import pc_ras_pkg::*;
#(
    parameter int DATAWIDTH = DEF_DATAWIDTH,
    parameter int IMMWIDTH  = DEF_IMMWIDTH
);
    logic                 pcEn, branch, jump, call, ret;
    logic [IMMWIDTH-1:0]  disp;
    logic [DATAWIDTH-1:0] dSrc, pc, pc_ra;
    logic                 ras_empty, ras_full, ras_ovf, ras_unf;

    modport master (
        output pcEn, branch, jump, call, ret, disp, dSrc,
        input  pc, pc_ra, ras_empty, ras_full, ras_ovf, ras_unf
    );
    modport slave (
        input  pcEn, branch, jump, call, ret, disp, dSrc,
        output pc, pc_ra, ras_empty, ras_full, ras_ovf, ras_unf
    );
endinterface

// File: rtl/pc_ras_ras_stack.sv
// ras_stack: circular return-address stack; ptr_q indexes the current top, a full push overwrites the oldest entry.
module ras_stack #(
    parameter int DATAWIDTH = 16,
    parameter int RAS_DEPTH = 4
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 push,
    input  logic                 pop,
    input  logic [DATAWIDTH-1:0] wdata,
    output logic [DATAWIDTH-1:0] top,
    output logic                 empty,
    output logic                 full,
    output logic                 ovf_evt,
    output logic                 unf_evt
);
    localparam int PW = $clog2(RAS_DEPTH);
    localparam int CW = $clog2(RAS_DEPTH + 1);

    logic [DATAWIDTH-1:0] mem_q [RAS_DEPTH];
    logic [PW-1:0]        ptr_q, ptr_d, widx;
    logic [CW-1:0]        cnt_q, cnt_d;
    logic                 swap;

    assign empty   = cnt_q == '0;
    assign full    = cnt_q == CW'(RAS_DEPTH);
    assign swap    = push && pop && !empty;
    assign top     = mem_q[ptr_q];
    assign ovf_evt = push && !swap && full;
    assign unf_evt = pop && !push && empty;

    always_comb begin
        widx  = swap ? ptr_q : ptr_q + PW'(1);
        ptr_d = swap ? ptr_q : push ? ptr_q + PW'(1) : (pop && !empty) ? ptr_q - PW'(1) : ptr_q;
        cnt_d = swap ? cnt_q : push ? (full ? cnt_q : cnt_q + CW'(1)) :
                (pop && !empty) ? cnt_q - CW'(1) : cnt_q;
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            ptr_q <= '0;
            cnt_q <= '0;
        end else begin
            ptr_q <= ptr_d;
            cnt_q <= cnt_d;
        end
    end

    always_ff @(posedge clk) begin
        if (push) mem_q[widx] <= wdata;
    end
endmodule

// File: rtl/pc_ras.sv
// pc_ras: fetch-stage PC with seq/branch/jump select and a return-address stack for call/ret.
// PC_RAS_ERR_EN: when defined, ras_ovf/ras_unf are sticky flops; otherwise they are tied low.
module pc_ras
    import pc_ras_pkg::*;
#(
    parameter int                   DATAWIDTH    = DEF_DATAWIDTH,
    parameter int                   IMMWIDTH     = DEF_IMMWIDTH,
    parameter int                   RAS_DEPTH    = 4,
    parameter logic [DATAWIDTH-1:0] RESET_VECTOR = '0
) (
    input logic     clk,
    input logic     rst,
    pc_ras_if.slave bus
);
    logic [DATAWIDTH-1:0] pc_q, pc_d, seq, br, top;
    logic                 empty, full;
    npc_sel_e             sel;

    assign seq = pc_q + DATAWIDTH'(1);
    assign br  = pc_q + DATAWIDTH'($signed(bus.disp));
    assign sel = npc_select(bus.branch, bus.jump, bus.call, bus.ret, empty);

    always_comb begin
        pc_d = !bus.pcEn                           ? pc_q     :
               (sel == NPC_RET || sel == NPC_SWAP) ? top      :
               (sel == NPC_JMP || sel == NPC_CALL) ? bus.dSrc :
               (sel == NPC_BR)                     ? br       : seq;
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) pc_q <= RESET_VECTOR;
        else      pc_q <= pc_d;
    end

`ifdef PC_RAS_ERR_EN
    logic ovf_evt, unf_evt, ovf_q, unf_q;
`endif

    ras_stack #(.DATAWIDTH(DATAWIDTH), .RAS_DEPTH(RAS_DEPTH)) u_stack (
        .clk     (clk),
        .rst     (rst),
        .push    (bus.pcEn && bus.call),
        .pop     (bus.pcEn && bus.ret),
        .wdata   (seq),
        .top     (top),
        .empty   (empty),
        .full    (full),
`ifdef PC_RAS_ERR_EN
        .ovf_evt (ovf_evt),
        .unf_evt (unf_evt)
`else
        .ovf_evt (),
        .unf_evt ()
`endif
    );

`ifdef PC_RAS_ERR_EN
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            ovf_q <= 1'b0;
            unf_q <= 1'b0;
        end else begin
            ovf_q <= ovf_q || ovf_evt;
            unf_q <= unf_q || unf_evt;
        end
    end
    assign bus.ras_ovf = ovf_q;
    assign bus.ras_unf = unf_q;
`else
    assign bus.ras_ovf = 1'b0;
    assign bus.ras_unf = 1'b0;
`endif

    assign bus.pc        = pc_q;
    assign bus.pc_ra     = bus.branch ? br : seq;
    assign bus.ras_empty = empty;
    assign bus.ras_full  = full;
endmodule

// File: tb/tb_pc_ras.sv
// tb_pc_ras: directed checks of pc_ras with RESET_VECTOR=0x0100 and RAS_DEPTH=4.
module tb_pc_ras;
    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    pc_ras_if #(.DATAWIDTH(16), .IMMWIDTH(8)) bus ();

    pc_ras #(
        .DATAWIDTH(16), .IMMWIDTH(8), .RAS_DEPTH(4), .RESET_VECTOR(16'h0100)
    ) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

`ifdef PC_RAS_ERR_EN
    localparam logic ERR = 1'b1;
`else
    localparam logic ERR = 1'b0;
`endif

    int n_chk = 0;
    int n_bad = 0;

    task automatic chk(input string tag, input logic [15:0] got, input logic [15:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic drv(input logic en, input logic b, input logic j, input logic c, input logic r,
                       input logic [7:0] d, input logic [15:0] s);
        bus.pcEn   = en;
        bus.branch = b;
        bus.jump   = j;
        bus.call   = c;
        bus.ret    = r;
        bus.disp   = d;
        bus.dSrc   = s;
    endtask

    task automatic step(input logic en, input logic b, input logic j, input logic c, input logic r,
                        input logic [7:0] d, input logic [15:0] s);
        drv(en, b, j, c, r, d, s);
        @(posedge clk);
        #1;
    endtask

    initial begin
        drv(0, 0, 0, 0, 0, 8'h00, 16'h0000);
        #2 rst = 1'b0;
        #1;
        chk("rst_pc", bus.pc, 16'h0100);
        chk("rst_empty", bus.ras_empty, 1);
        chk("rst_full", bus.ras_full, 0);
        chk("rst_ovf", bus.ras_ovf, 0);
        chk("rst_unf", bus.ras_unf, 0);
        #9 rst = 1'b1;

        step(1, 0, 0, 0, 0, 8'h00, 16'h0000); chk("seq1", bus.pc, 16'h0101);
        step(1, 0, 0, 0, 0, 8'h00, 16'h0000); chk("seq2", bus.pc, 16'h0102);
        step(1, 0, 0, 0, 0, 8'h00, 16'h0000); chk("seq3", bus.pc, 16'h0103);
        chk("seq_empty", bus.ras_empty, 1);
        chk("seq_link", bus.pc_ra, 16'h0104);

        step(1, 0, 1, 0, 0, 8'h00, 16'h0010); chk("jmp", bus.pc, 16'h0010);
        drv(1, 1, 0, 0, 0, 8'hFC, 16'h0000);
        #1 chk("br_link", bus.pc_ra, 16'h000C);
        step(1, 1, 0, 0, 0, 8'hFC, 16'h0000); chk("br_back", bus.pc, 16'h000C);
        step(1, 1, 1, 0, 0, 8'h7F, 16'h0200); chk("jmp_over_br", bus.pc, 16'h0200);
        step(1, 1, 0, 0, 0, 8'h05, 16'h0000); chk("br_fwd", bus.pc, 16'h0205);

        step(1, 0, 1, 0, 0, 8'h00, 16'hFFFF); chk("jmp_max", bus.pc, 16'hFFFF);
        step(1, 0, 0, 0, 0, 8'h00, 16'h0000); chk("wrap", bus.pc, 16'h0000);

        step(1, 0, 1, 0, 0, 8'h00, 16'h0020);
        step(1, 0, 0, 1, 0, 8'h00, 16'h0300); chk("call_pc", bus.pc, 16'h0300);
        chk("call_empty", bus.ras_empty, 0);
        step(1, 0, 0, 0, 0, 8'h00, 16'h0000);
        step(1, 0, 0, 0, 0, 8'h00, 16'h0000); chk("call_seq", bus.pc, 16'h0302);
        step(1, 1, 0, 0, 1, 8'h10, 16'h0000); chk("ret_pc", bus.pc, 16'h0021);
        chk("ret_empty", bus.ras_empty, 1);

        step(1, 0, 1, 0, 0, 8'h00, 16'h1000);
        step(1, 0, 0, 1, 0, 8'h00, 16'h2000);
        step(1, 0, 0, 1, 0, 8'h00, 16'h3000);
        step(1, 0, 0, 1, 0, 8'h00, 16'h4000);
        step(1, 0, 0, 1, 0, 8'h00, 16'h5000);
        chk("nest4_full", bus.ras_full, 1);
        chk("nest4_ovf", bus.ras_ovf, 0);
        step(1, 0, 0, 1, 0, 8'h00, 16'h6000); chk("nest5_pc", bus.pc, 16'h6000);
        chk("nest5_full", bus.ras_full, 1);
        chk("nest5_ovf", bus.ras_ovf, ERR);
        step(1, 0, 0, 0, 1, 8'h00, 16'h0000); chk("pop1", bus.pc, 16'h5001);
        chk("pop1_full", bus.ras_full, 0);
        step(1, 0, 0, 0, 1, 8'h00, 16'h0000); chk("pop2", bus.pc, 16'h4001);
        step(1, 0, 0, 0, 1, 8'h00, 16'h0000); chk("pop3", bus.pc, 16'h3001);
        step(1, 0, 0, 0, 1, 8'h00, 16'h0000); chk("pop4", bus.pc, 16'h2001);
        chk("pop4_empty", bus.ras_empty, 1);
        chk("pop4_unf", bus.ras_unf, 0);
        step(1, 0, 0, 0, 1, 8'h00, 16'h0000); chk("pop5", bus.pc, 16'h2002);
        chk("pop5_unf", bus.ras_unf, ERR);
        chk("ovf_sticky", bus.ras_ovf, ERR);

        step(1, 0, 1, 0, 0, 8'h00, 16'h004F);
        step(1, 0, 0, 1, 0, 8'h00, 16'h0400); chk("pre_swap", bus.pc, 16'h0400);
        step(1, 0, 0, 1, 1, 8'h00, 16'h0999); chk("swap_pc", bus.pc, 16'h0050);
        chk("swap_empty", bus.ras_empty, 0);
        step(0, 0, 0, 1, 0, 8'h00, 16'h0777); chk("hold_pc", bus.pc, 16'h0050);
        chk("hold_empty", bus.ras_empty, 0);
        chk("hold_link", bus.pc_ra, 16'h0051);
        step(0, 0, 1, 0, 1, 8'h00, 16'h0777); chk("hold2_pc", bus.pc, 16'h0050);
        step(1, 0, 0, 0, 1, 8'h00, 16'h0000); chk("swap_top", bus.pc, 16'h0401);
        chk("swap_cnt", bus.ras_empty, 1);

        step(1, 0, 0, 1, 0, 8'h00, 16'h0A00);
        step(1, 0, 0, 1, 0, 8'h00, 16'h0B00);
        step(1, 0, 0, 1, 0, 8'h00, 16'h0C00); chk("pre_rst", bus.pc, 16'h0C00);
        drv(1, 0, 0, 0, 0, 8'h00, 16'h0000);
        #2 rst = 1'b0;
        #1;
        chk("arst_pc", bus.pc, 16'h0100);
        chk("arst_empty", bus.ras_empty, 1);
        chk("arst_ovf", bus.ras_ovf, 0);
        chk("arst_unf", bus.ras_unf, 0);
        #3 rst = 1'b1;
        step(1, 0, 0, 0, 1, 8'h00, 16'h0000); chk("post_rst_ret", bus.pc, 16'h0101);
        chk("post_rst_unf", bus.ras_unf, ERR);

        $display("test done: total=%0d bad=%0d", n_chk, n_bad);
        $finish;
    end

    initial begin
        #50000;
        $display("FAIL timeout: got running expected finished");
        $fatal(1);
    end
endmodule
